fec_stream_encoder: RTL and testbench

Streaming successor to the fixed 32-bit CRC+FEC encoder. Accepts a serial payload of parametrised length under a valid/ready handshake, computes a serial CRC inline, and appends it. It optionally appends a trellis-terminating tail, then emits a rate-1/2, K=3 convolutional code stream as bit pairs with output backpressure. It sits between the frame source and the serialiser/modulator.

---
 rtl/fec_pkg.sv | 25 ++
 rtl/fec_stream_encoder_if.sv | 21 ++
 rtl/crc_serial.sv | 41 ++++
 rtl/fec_stream_encoder.sv | 147 ++++++++++++++
 tb/tb_fec_stream_encoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fec_pkg.sv
// Shared types and constants for the streaming CRC + rate-1/2 K=3 convolutional encoder.
package fec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CRC,
        ST_TAIL,
        ST_DONE
    } fec_state_t;

    localparam int FEC_K = 3;
    localparam logic [FEC_K-1:0] FEC_G0 = 3'b111;
    localparam logic [FEC_K-1:0] FEC_G1 = 3'b101;

    localparam logic [15:0] FEC_CRC_POLY = 16'h1021;
    localparam logic [15:0] FEC_CRC_INIT = 16'h0000;

    // Parity of the {b, d1, d2} window under one generator polynomial.
    function automatic logic fec_parity(input logic [FEC_K-1:0] window,
                                        input logic [FEC_K-1:0] gen);
        return ^(window & gen);
    endfunction

endpackage

// File: rtl/fec_stream_encoder_if.sv
// Payload-in / code-pair-out handshake bundle of fec_stream_encoder.
interface fec_stream_encoder_if;

    logic       data_in;
    logic       data_valid_in;
    logic       data_ready_out;
    logic [1:0] code_out;
    logic       code_valid_out;
    logic       code_ready_in;

    modport master (
        output data_in, data_valid_in, code_ready_in,
        input  data_ready_out, code_out, code_valid_out
    );

    modport slave (
        input  data_in, data_valid_in, code_ready_in,
        output data_ready_out, code_out, code_valid_out
    );

endinterface

// File: rtl/crc_serial.sv
// Bit-serial MSB-first CRC register, non-reflected, no final XOR.
module crc_serial
    import fec_pkg::*;
#(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = FEC_CRC_POLY,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT  = FEC_CRC_INIT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear_in,
    input  logic                 en_in,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc_out
);

    logic [CRC_WIDTH-1:0] crc_reg;
    logic [CRC_WIDTH-1:0] crc_next;
    logic                 fb;

    assign fb          = crc_reg[CRC_WIDTH-1] ^ bit_in;
    assign crc_next[0] = fb & CRC_POLY[0];

    genvar gi;
    generate
        for (gi = 1; gi < CRC_WIDTH; gi++) begin : g_tap
            assign crc_next[gi] = crc_reg[gi-1] ^ (fb & CRC_POLY[gi]);
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            crc_reg <= CRC_INIT;
        end else if (en_in) begin
            crc_reg <= crc_next;
        end
    end

    assign crc_out = crc_reg;

endmodule

// File: rtl/fec_stream_encoder.sv
// Streaming CRC append + rate-1/2 K=3 convolutional encoder with output backpressure.
// Define FEC_TAIL_EN to append two zero bits that terminate the trellis in state 00.
module fec_stream_encoder
    import fec_pkg::*;
#(
    parameter int                   DATA_BITS = 32,
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = FEC_CRC_POLY,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT  = FEC_CRC_INIT
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         start_in,
    fec_stream_encoder_if.slave                          stream,
    output logic [CRC_WIDTH-1:0]                         crc_out,
    output logic [$clog2(DATA_BITS+CRC_WIDTH+3)-1:0]     bit_count_out,
    output logic                                         busy_out,
    output logic                                         done_out
);

    localparam int CNT_W = $clog2(DATA_BITS + CRC_WIDTH + 3);
    localparam logic [CNT_W-1:0]     LOAD_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]     CRC_START = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0]     CRC_END   = CNT_W'(DATA_BITS + CRC_WIDTH);
    localparam logic [CRC_WIDTH-1:0] CRC_MSB   = {1'b1, {(CRC_WIDTH-1){1'b0}}};
`ifdef FEC_TAIL_EN
    localparam logic [CNT_W-1:0]     TAIL_END  = CNT_W'(DATA_BITS + CRC_WIDTH + 2);
`endif

    fec_state_t           state_reg;
    logic [1:0]           enc_reg;          // {d1, d2}
    logic [1:0]           code_reg;
    logic                 code_valid_reg;
    logic [CNT_W-1:0]     bit_count_reg;

    logic [CRC_WIDTH-1:0] crc_val;
    logic [CNT_W-1:0]     crc_pos;
    logic                 adv;
    logic                 has_bit;
    logic                 consume;
    logic                 src_bit;
    logic [FEC_K-1:0]     window;

    assign adv     = !code_valid_reg || stream.code_ready_in;
    assign crc_pos = bit_count_reg - CRC_START;

    // CRC bits are read out of the frozen register by position so crc_out keeps the final value.
    always_comb begin
        has_bit = 1'b0;
        src_bit = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                has_bit = stream.data_valid_in;
                src_bit = stream.data_in;
            end
            ST_CRC: begin
                has_bit = bit_count_reg < CRC_END;
                src_bit = |(crc_val & (CRC_MSB >> crc_pos));
            end
`ifdef FEC_TAIL_EN
            ST_TAIL: begin
                has_bit = bit_count_reg < TAIL_END;
            end
`endif
            default: ;
        endcase
    end

    assign consume = has_bit && adv;
    assign window  = {src_bit, enc_reg};

    crc_serial #(
        .CRC_WIDTH (CRC_WIDTH),
        .CRC_POLY  (CRC_POLY),
        .CRC_INIT  (CRC_INIT)
    ) u_crc (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (start_in),
        .en_in    (consume && (state_reg == ST_LOAD)),
        .bit_in   (src_bit),
        .crc_out  (crc_val)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= ST_IDLE;
            enc_reg        <= 2'b00;
            code_reg       <= 2'b00;
            code_valid_reg <= 1'b0;
            bit_count_reg  <= '0;
        end else if (start_in) begin
            state_reg      <= ST_LOAD;
            enc_reg        <= 2'b00;
            code_reg       <= 2'b00;
            code_valid_reg <= 1'b0;
            bit_count_reg  <= '0;
        end else begin
            if (consume) begin
                code_reg       <= {fec_parity(window, FEC_G0), fec_parity(window, FEC_G1)};
                code_valid_reg <= 1'b1;
                enc_reg        <= {src_bit, enc_reg[1]};
                bit_count_reg  <= bit_count_reg + 1'b1;
            end else if (stream.code_ready_in) begin
                code_valid_reg <= 1'b0;
            end

            // The final phase lingers with no bits left until its last pair is taken.
            case (state_reg)
                ST_LOAD: begin
                    if (consume && bit_count_reg == LOAD_LAST) begin
                        state_reg <= ST_CRC;
                    end
                end
`ifdef FEC_TAIL_EN
                ST_CRC: begin
                    if (consume && bit_count_reg == CRC_END - 1'b1) begin
                        state_reg <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (!has_bit && adv) begin
                        state_reg <= ST_DONE;
                    end
                end
`else
                ST_CRC: begin
                    if (!has_bit && adv) begin
                        state_reg <= ST_DONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign stream.data_ready_out = (state_reg == ST_LOAD) && adv;
    assign stream.code_out       = code_reg;
    assign stream.code_valid_out = code_valid_reg;
    assign crc_out               = crc_val;
    assign bit_count_out         = bit_count_reg;
    assign busy_out              = (state_reg == ST_LOAD) || (state_reg == ST_CRC) ||
                                   (state_reg == ST_TAIL);
    assign done_out              = (state_reg == ST_DONE);

endmodule

// File: tb/tb_fec_stream_encoder.sv
// Bench for fec_stream_encoder: table of frames checked against a reference model via a pair scoreboard.
module tb_fec_stream_encoder;

`ifdef FEC_TAIL_EN
    localparam int TAIL_BITS = 2;
`else
    localparam int TAIL_BITS = 0;
`endif
    localparam int PAIRS_A = 32 + 16 + TAIL_BITS;
    localparam int PAIRS_B = 72 + 16 + TAIL_BITS;
    localparam int BUDGET  = 3000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_a, start_b;
    logic [15:0] crc_a, crc_b;
    logic [5:0]  cnt_a;
    logic [6:0]  cnt_b;
    logic        busy_a, done_a, busy_b, done_b;

    fec_stream_encoder_if sa ();
    fec_stream_encoder_if sb ();

    always #5 clk_in = ~clk_in;

    fec_stream_encoder #(.DATA_BITS(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_a), .stream(sa),
        .crc_out(crc_a), .bit_count_out(cnt_a), .busy_out(busy_a), .done_out(done_a)
    );

    fec_stream_encoder #(.DATA_BITS(72)) dut72 (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b), .stream(sb),
        .crc_out(crc_b), .bit_count_out(cnt_b), .busy_out(busy_b), .done_out(done_b)
    );

    typedef struct {
        logic [31:0] payload;
        bit          stall;
        bit          gap;
        logic [5:0]  exp_head;   // first three expected pairs, oldest in the MSBs
    } vec_t;

    vec_t       vecs [6];
    int         errors = 0;
    int         checks = 0;
    int         cyc_cnt = 0;
    int         last_hs_cyc = 0;
    int         b_pairs = 0;
    bit         mon_en = 1'b0;
    logic [1:0] exp_q [$];
    logic [1:0] got_q [$];

    always @(posedge clk_in) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard: every pair that handshakes on the next edge is compared with the model.
    always @(negedge clk_in) begin
        if (mon_en && sa.code_valid_out && sa.code_ready_in) begin
            got_q.push_back(sa.code_out);
            last_hs_cyc = cyc_cnt;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_pair: got %b, required no pair", sa.code_out);
            end else begin
                logic [1:0] exp;
                exp = exp_q.pop_front();
                if (exp !== sa.code_out) begin
                    errors++;
                    $display("FAIL pair%0d: got %b, required %b", got_q.size() - 1, sa.code_out, exp);
                end else begin
                    $display("pair %0d: %b", got_q.size() - 1, sa.code_out);
                end
            end
        end
        if (sb.code_valid_out && sb.code_ready_in) begin
            b_pairs++;
            $display("b pair %0d: %b", b_pairs - 1, sb.code_out);
        end
    end

    task automatic push_enc(input logic b, inout logic [1:0] st);
        exp_q.push_back({b ^ st[1] ^ st[0], b ^ st[0]});
        st = {b, st[1]};
    endtask

    task automatic model_frame(input logic [31:0] pl, output logic [15:0] crc);
        logic [15:0] c;
        logic [1:0]  st;
        logic        fb;
        c  = 16'h0000;
        st = 2'b00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ pl[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            push_enc(pl[i], st);
        end
        for (int i = 15; i >= 0; i--) push_enc(c[i], st);
        for (int i = 0; i < TAIL_BITS; i++) push_enc(1'b0, st);
        crc = c;
    endtask

    task automatic send_frame(input logic [31:0] pl, input bit stall, input bit gap,
                              input bit do_start, input bit checked);
        int          idx;
        int          cyc;
        logic [15:0] mcrc;
        mcrc = 16'h0000;
        if (checked) begin
            got_q.delete();
            model_frame(pl, mcrc);
        end
        if (do_start) begin
            sa.data_valid_in = 1'b0;
            start_a = 1'b1;
            @(posedge clk_in); #1;
            start_a = 1'b0;
        end
        idx = 0;
        cyc = 0;
        while (idx < 32 && cyc < BUDGET) begin
            sa.data_valid_in = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            sa.data_in       = pl[31 - idx];
            sa.code_ready_in = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk_in);
            if (sa.data_valid_in && sa.data_ready_out) idx++;
            @(posedge clk_in); #1;
            cyc++;
        end
        sa.data_valid_in = 1'b0;
        check("payload_accepted", idx, 32);
        if (checked) begin
            while (!done_a && cyc < BUDGET) begin
                sa.code_ready_in = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(posedge clk_in); #1;
                cyc++;
            end
            sa.code_ready_in = 1'b1;
            check("done_a", done_a, 1);
            check("done_after_last_hs", cyc_cnt, last_hs_cyc + 1);
            check("pair_count_a", got_q.size(), PAIRS_A);
            check("queue_drained", exp_q.size(), 0);
            check("crc_a", crc_a, mcrc);
            check("bit_count_a", cnt_a, PAIRS_A);
            check("busy_a_done", busy_a, 0);
        end
    endtask

    initial begin
        logic [71:0] msg;
        logic [5:0]  head;
        int          idx;
        int          cyc;

        rst_in = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sa.data_in = 1'b1;
        sa.data_valid_in = 1'b1;
        sa.code_ready_in = 1'b1;
        sb.data_in = 1'b0;
        sb.data_valid_in = 1'b0;
        sb.code_ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (4) begin @(posedge clk_in); #1; end

        // Idle after reset: data_valid_in is high but must be ignored.
        check("rst_data_ready", sa.data_ready_out, 0);
        check("rst_code_valid", sa.code_valid_out, 0);
        check("rst_code_out", sa.code_out, 0);
        check("rst_crc", crc_a, 0);
        check("rst_bit_count", cnt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        sa.data_valid_in = 1'b0;

        vecs[0] = '{32'h0000_0000, 1'b0, 1'b0, 6'b000000};
        vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 6'b111011};
        vecs[2] = '{32'hA5C3_0F1E, 1'b1, 1'b1, 6'b111000};
        vecs[3] = '{32'h8000_0000, 1'b1, 1'b1, 6'b111011};
        vecs[4] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 6'b110110};
        vecs[5] = '{32'h1234_5678, 1'b0, 1'b1, 6'b000000};

        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            $display("frame %0d payload %h stall=%0d gap=%0d", i, vecs[i].payload, vecs[i].stall, vecs[i].gap);
            send_frame(vecs[i].payload, vecs[i].stall, vecs[i].gap, 1'b1, 1'b1);
            head = {got_q[0], got_q[1], got_q[2]};
            check("head_pairs", head, vecs[i].exp_head);
            if (vecs[i].payload == 32'h0) check("crc_zero", crc_a, 0);
        end

        // Abort mid-CRC phase, then run a fresh frame without another start.
        mon_en = 1'b0;
        send_frame(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk_in); #1; end
        check("busy_mid_crc", busy_a, 1);
        check("in_crc_phase", (cnt_a >= 6'd32) && (cnt_a < 6'd48), 1);
        start_a = 1'b1;
        @(posedge clk_in); #1;
        start_a = 1'b0;
        check("abort_code_valid", sa.code_valid_out, 0);
        check("abort_bit_count", cnt_a, 0);
        check("abort_data_ready", sa.data_ready_out, 1);
        check("abort_done", done_a, 0);
        exp_q.delete();
        mon_en = 1'b1;
        send_frame(32'h0F0F_A55A, 1'b0, 1'b0, 1'b0, 1'b1);

        // 72-bit instance: check value of "123456789".
        msg = "123456789";
        start_b = 1'b1;
        @(posedge clk_in); #1;
        start_b = 1'b0;
        sb.data_valid_in = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 72 && cyc < BUDGET) begin
            sb.data_in = msg[71 - idx];
            @(negedge clk_in);
            if (sb.data_ready_out) idx++;
            @(posedge clk_in); #1;
            cyc++;
        end
        sb.data_valid_in = 1'b0;
        while (!done_b && cyc < BUDGET) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        check("b_done", done_b, 1);
        check("b_crc_check", crc_b, 16'h31C3);
        check("b_pair_count", b_pairs, PAIRS_B);
        check("b_bit_count", cnt_b, PAIRS_B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
